// File: rtl/sreg_ctrl_pkg.sv
// Shared types and helpers for the serial shift-register load controller.
// Imported by the controller and by its testbench.
package sreg_ctrl_pkg;

    typedef enum logic {IDLE, SHIFT} ctrl_state_t;

    // Bits needed to index a frame of 'width' bits; never less than 1.
    function automatic int clog2w(input int width);
        int n;
        n = 1;
        while ((1 << n) < width) n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/sreg_load_ctrl_if.sv
// Parallel-in handshake and serial-out strobe bundle for sreg_load_ctrl.
// The source side drives through 'master'; the controller uses 'slave'.
interface sreg_load_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             msb_first;
    logic [DIV_W-1:0] div;
    logic             abort;
    logic             ser_out;
    logic             ser_en;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, msb_first, div, abort,
        input  in_ready, ser_out, ser_en, busy, done
    );

    modport slave (
        input  in_valid, in_data, msb_first, div, abort,
        output in_ready, ser_out, ser_en, busy, done
    );
endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit period of div_q+1 cycles.
// 'first' is a registered flag high during the first cycle of each period.
module bit_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] div_q,
    output logic             tick,
    output logic             first
);

    logic [DIV_W-1:0] tick_cnt;

    assign tick = (tick_cnt == div_q);

    // The count parks at div_q when no new period is requested, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            first    <= 1'b0;
        end else if (start) begin
            tick_cnt <= '0;
            first    <= 1'b1;
        end else begin
            first <= 1'b0;
            if (!tick) tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sreg_load_ctrl.sv
// Accepts a parallel word over valid/ready and streams it bit by bit on ser_out,
// with a ser_en strobe at the start of each programmable-length bit period.
module sreg_load_ctrl
    import sreg_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input logic           clk,
    input logic           rst,
    sreg_load_ctrl_if.slave bus
);

    localparam int             BCW      = clog2w(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    ctrl_state_t      state;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] data_q;
    logic             msb_q;
    logic [DIV_W-1:0] div_q;
    logic             ser_out_q;
    logic             busy_q;
    logic             done_q;
    logic             ser_en_q;
    logic             in_ready_c;
    logic             accept;
    logic             last_bit;
    logic             tick;
    logic             start;

    function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                      input logic             msb,
                                      input logic [BCW-1:0]   k);
        logic [BCW-1:0] idx;
        idx = msb ? (LAST_BIT - k) : k;
        return word[idx];
    endfunction

    assign in_ready_c = (state == IDLE) && !bus.abort;
    assign accept     = bus.in_valid && in_ready_c;
    assign last_bit   = (bit_cnt == LAST_BIT);
    // A new bit period begins at accept or at the end of every bit except the last.
    assign start      = accept || ((state == SHIFT) && !bus.abort && tick && !last_bit);

    bit_timer #(
        .DIV_W(DIV_W)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .div_q(div_q),
        .tick (tick),
        .first(ser_en_q)
    );

    // Frame settings are frozen at accept; later input changes cannot disturb a frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= bus.in_data;
            msb_q  <= bus.msb_first;
            div_q  <= bus.div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            ser_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        busy_q    <= 1'b1;
                        ser_out_q <= pick_bit(bus.in_data, bus.msb_first, '0);
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        ser_out_q <= 1'b0;
                    end else if (tick) begin
                        if (last_bit) begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            ser_out_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            ser_out_q <= pick_bit(data_q, msb_q, bit_cnt + 1'b1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.ser_out  = ser_out_q;
    assign bus.ser_en   = ser_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sreg_load_ctrl.sv
// Directed bench for sreg_load_ctrl: per-cycle vector tables for the normal frames
// and hand-written sequences for abort and reset corner cases.
module tb_sreg_load_ctrl;

    logic clk;
    logic rst;

    sreg_load_ctrl_if #(.WIDTH(4), .DIV_W(8)) bus ();

    sreg_load_ctrl #(.WIDTH(4), .DIV_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs driven in a cycle plus the outputs expected in that same cycle.
    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] data;
        logic       msb;
        logic [7:0] div;
        logic       abort;
        logic       e_ready;
        logic       e_out;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   failures;
    int   done_seen;
    int   hidx;
    int   d0;

    function automatic vec_t mk(input int r, v, d, m, dv, ab, er, eo, ee, eb, ed);
        vec_t x;
        x.rst     = r[0];
        x.valid   = v[0];
        x.data    = d[3:0];
        x.msb     = m[0];
        x.div     = dv[7:0];
        x.abort   = ab[0];
        x.e_ready = er[0];
        x.e_out   = eo[0];
        x.e_en    = ee[0];
        x.e_busy  = eb[0];
        x.e_done  = ed[0];
        return x;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        rst           = x.rst;
        bus.in_valid  = x.valid;
        bus.in_data   = x.data;
        bus.msb_first = x.msb;
        bus.div       = x.div;
        bus.abort     = x.abort;
        #1;
        chk({tag, ".in_ready"}, bus.in_ready, x.e_ready);
        chk({tag, ".ser_out"},  bus.ser_out,  x.e_out);
        chk({tag, ".ser_en"},   bus.ser_en,   x.e_en);
        chk({tag, ".busy"},     bus.busy,     x.e_busy);
        chk({tag, ".done"},     bus.done,     x.e_done);
        if (bus.done === 1'b1) done_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int r, v, d, m, dv, ab, er, eo, ee, eb, ed);
        tbl.push_back(mk(r, v, d, m, dv, ab, er, eo, ee, eb, ed));
    endtask

    task automatic row(input string seg, input int r, v, d, m, dv, ab, er, eo, ee, eb, ed);
        apply(mk(r, v, d, m, dv, ab, er, eo, ee, eb, ed), $sformatf("%s[%0d]", seg, hidx));
        hidx++;
    endtask

    task automatic run_table(input string seg);
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("%s[%0d]", seg, i));
        tbl.delete();
    endtask

    initial begin
        checks = 0; failures = 0; done_seen = 0; hidx = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.msb_first = 1'b0;
        bus.div = '0; bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, and abort masking in_ready in IDLE
        row("reset", 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        row("reset", 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        row("reset", 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);

        // Test 1: 1011, msb first, div 0
        add(0, 1, 4'hB, 1, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        d0 = done_seen;
        run_table("t1");
        chk_int("t1.done_count", done_seen - d0, 1);

        // Test 2: 1011, lsb first, div 2; settings inputs scrambled after accept
        add(0, 1, 4'hB, 0, 2, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        d0 = done_seen;
        run_table("t2");
        chk_int("t2.done_count", done_seen - d0, 1);

        // Test 3: A then B=5 held valid, accepted in A's done cycle
        add(0, 1, 4'hA, 1, 0, 0,  1, 0, 0, 0, 0);
        add(0, 1, 4'h5, 1, 0, 0,  0, 1, 1, 1, 0);
        add(0, 1, 4'h5, 1, 0, 0,  0, 0, 1, 1, 0);
        add(0, 1, 4'h5, 1, 0, 0,  0, 1, 1, 1, 0);
        add(0, 1, 4'h5, 1, 0, 0,  0, 0, 1, 1, 0);
        add(0, 1, 4'h5, 1, 0, 0,  1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        d0 = done_seen;
        run_table("t3");
        chk_int("t3.done_count", done_seen - d0, 2);

        // Test 4: F offered with div 7 during A; A keeps div 0; F then aborted in bit 1
        add(0, 1, 4'hA, 1, 0, 0,  1, 0, 0, 0, 0);
        add(0, 1, 4'hF, 0, 7, 0,  0, 1, 1, 1, 0);
        add(0, 1, 4'hF, 0, 7, 0,  0, 0, 1, 1, 0);
        add(0, 1, 4'hF, 0, 7, 0,  0, 1, 1, 1, 0);
        add(0, 1, 4'hF, 0, 7, 0,  0, 0, 1, 1, 0);
        add(0, 1, 4'hF, 0, 7, 0,  1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0,     0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1,     0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        d0 = done_seen;
        run_table("t4");
        chk_int("t4.done_count", done_seen - d0, 1);

        // Test 5a: abort at T+2 of a div 0 frame
        d0 = done_seen; hidx = 0;
        row("t5", 0, 1, 4'hF, 1, 0, 0,  1, 0, 0, 0, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        row("t5", 0, 0, 0, 0, 0, 1,     0, 1, 1, 1, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) row("t5", 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        // Test 5b: abort on the final tick suppresses done
        row("t5", 0, 1, 4'hF, 1, 0, 0,  1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) row("t5", 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
        row("t5", 0, 0, 0, 0, 0, 1,     0, 1, 1, 1, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        // Test 5c: abort in IDLE blocks an offered word
        row("t5", 0, 1, 4'hF, 1, 0, 1,  0, 0, 0, 0, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        row("t5", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        chk_int("t5.done_count", done_seen - d0, 0);

        // Test 6: rst during bit 1 of a div 3 frame, then a fresh accept right after
        d0 = done_seen; hidx = 0;
        row("t6", 0, 1, 4'hB, 1, 3, 0,  1, 0, 0, 0, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) row("t6", 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        row("t6", 1, 0, 0, 0, 0, 0,     0, 0, 0, 1, 0);
        row("t6", 0, 1, 4'h6, 1, 0, 0,  1, 0, 0, 0, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     0, 0, 1, 1, 0);
        row("t6", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1);
        row("t6", 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0);
        chk_int("t6.done_count", done_seen - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sreg_load_ctrl.md
Name: sreg_load_ctrl

Overview:
Controller that sequences the team's serial shift-register datapath. It accepts a parallel word over a valid/ready handshake and emits it one bit at a time on a serial line, with a per-bit shift strobe at a programmable bit rate. It sits between the signal-generator sample source and the downstream shift register (data_in/clk), so a parallel sample can be streamed into that register.

Parameters:
WIDTH, 4, bits per frame (matches the downstream 4-stage register); legal range is 2..32.
DIV_W, 8, width of the bit-period divisor input.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  a parallel word is offered.
in_ready  output  1  the controller can accept a word.
in_data  input  WIDTH  the parallel word.
msb_first  input  1  bit order; 1 sends in_data[WIDTH-1] first. Sampled at accept.
div  input  DIV_W  bit period minus 1, in clk cycles. Sampled at accept.
abort  input  1  synchronous frame cancel.
ser_out  output  1  serial bit to the downstream register's data_in.
ser_en  output  1  one-cycle strobe marking the first cycle of each bit.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset values: state IDLE, ser_out=0, ser_en=0, busy=0, done=0. in_ready=1 in the first cycle after reset, unless abort is high.
- in_ready is combinational: in_ready = (state==IDLE) && !abort.
- All other outputs are registered.
- FSM has two states, IDLE and SHIFT.
- Accept happens at a rising edge with in_valid && in_ready (call this edge T). At that edge:
  - capture in_data, msb_first and div into internal registers;
  - bit_cnt <= 0 and tick_cnt <= 0;
  - go to SHIFT.
- Changes on div, msb_first or in_data after accept have no effect on the current frame.
- In SHIFT, bit k (k = 0..WIDTH-1) is on ser_out during cycles T+1+k*(D+1) through T+(k+1)*(D+1), where D is the captured div.
- ser_en=1 only in the first cycle of each bit period. With D=0, ser_en stays high for WIDTH consecutive cycles.
- busy=1 in every SHIFT cycle.
- Bit selection: msb_first=1 sends in_data[WIDTH-1-k]; msb_first=0 sends in_data[k].
- Frame end: on the last cycle of bit WIDTH-1 the FSM returns to IDLE. In the next cycle (T+1+WIDTH*(D+1)):
  - done=1, ser_out=0, busy=0;
  - in_ready=1, so a new word can be accepted in the same cycle that done is high (back-to-back frames, one idle cycle between bit streams).
- While in SHIFT, in_ready=0; in_valid is ignored and the word must be held by the source.
- Counters: tick_cnt is DIV_W bits and compares against D, so it cannot wrap. bit_cnt is clog2(WIDTH) bits and resets at accept.
- abort:
  - In SHIFT: the next cycle is IDLE with ser_out=0, ser_en=0, busy=0 and done=0.
  - Abort on the final tick also wins: no done pulse.
  - abort in IDLE blocks acceptance for that cycle.
- rst at any time overrides abort and in_valid. Outputs take their reset values in the next cycle, and a partial frame is dropped without a done pulse.
- The controller never forces the downstream register; it only drives ser_out and ser_en.

Decomposition:
- Package sreg_ctrl_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ctrl_state_t;
  - function clog2w(WIDTH) for the bit_cnt width.
- Sub-module bit_timer (parameter DIV_W):
  - inputs: clk, rst, start, div_q;
  - outputs: tick (last cycle of the period) and first (first cycle of the period);
  - the FSM instantiates one.

Test Plan:
1. WIDTH=4, div=0, msb_first=1, in_data=4'b1011, accept at T → ser_out 1,0,1,1 in cycles T+1..T+4; ser_en=1 in T+1..T+4; done=1 only at T+5; busy=0 at T+5.
2. Same word, msb_first=0, div=2 → ser_out 1,1,0,1, each held 3 cycles (T+1..T+12); ser_en at T+1, T+4, T+7, T+10; done at T+13.
3. Back-to-back: frame A=4'hA, then in_valid held with B=4'h5 (div=0, msb_first=1) → B accepted at the T+5 edge; B's bits 0,1,0,1 appear at T+6..T+9; exactly two done pulses.
4. in_valid with in_data=4'hF during frame A, div changed to 7 mid-frame → in_ready=0 throughout A; A keeps the original timing; the new word is accepted only after A's done.
5. abort asserted at T+2 of a div=0 frame → at T+3 ser_out=0, busy=0, no done ever; abort in IDLE with in_valid=1 → no accept that cycle.
6. rst for one cycle at T+6 of a div=3 frame → at T+7 all outputs are at reset values; no done; a new accept is possible on the following edge.
